// File: rtl/axi_mem_responder.sv
// AXI4 slave scratch RAM: 1R1W array of 512-bit words, INCR/FIXED bursts, SLVERR on bad beats.
// Latency: R beat 2 cycles after AR or R handshake; wready 1 cycle after AW; B 1 cycle after last W.
// Backpressure: one burst per direction in flight; R/B payload held stable until the master is ready.
package fpga_pkg;
   typedef struct packed {
      logic [7:0]   aw_id;
      logic [31:0]  aw_addr;
      logic [7:0]   aw_len;
      logic [2:0]   aw_size;
      logic [1:0]   aw_burst;
      logic [5:0]   aw_atop;
      logic         aw_valid;
      logic [511:0] w_data;
      logic [63:0]  w_strb;
      logic         w_last;
      logic         w_valid;
      logic         b_ready;
      logic [7:0]   ar_id;
      logic [31:0]  ar_addr;
      logic [7:0]   ar_len;
      logic [2:0]   ar_size;
      logic [1:0]   ar_burst;
      logic         ar_valid;
      logic         r_ready;
   } mst_req_t;

   typedef struct packed {
      logic         aw_ready;
      logic         w_ready;
      logic [7:0]   b_id;
      logic [1:0]   b_resp;
      logic         b_valid;
      logic         ar_ready;
      logic [7:0]   r_id;
      logic [511:0] r_data;
      logic [1:0]   r_resp;
      logic         r_last;
      logic         r_valid;
   } mst_resp_t;
endpackage

module axi_mem_responder #(
   parameter int unsigned MEM_BYTES = 65536,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  fpga_pkg::mst_req_t  axi_req_i,
   output fpga_pkg::mst_resp_t axi_resp_o
);
   localparam int unsigned WORDS     = MEM_BYTES / 64;
   localparam int unsigned IDXW      = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [31:0] SPAN_MASK = ~(32'(MEM_BYTES) - 32'd1);

   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

   // BASE_ADDR is aligned to MEM_BYTES, so masking the offset bits is the range check.
   function automatic logic out_of_range(input logic [31:0] a);
      return (a & SPAN_MASK) != BASE_ADDR;
   endfunction

   function automatic logic [IDXW-1:0] word_idx(input logic [31:0] a);
      return IDXW'((a - BASE_ADDR) >> 6);
   endfunction

   // FIXED holds the address; INCR steps by the beat size (WRAP never gets here without error).
   function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                             input logic [1:0] burst);
      return (burst == 2'b00) ? a : a + (32'd1 << size);
   endfunction

   logic [511:0] mem_q [WORDS];

   r_state_e     r_state_q, r_state_d;
   logic [7:0]   r_id_q, r_id_d, r_len_q, r_len_d, r_beat_q, r_beat_d;
   logic [31:0]  r_addr_q, r_addr_d;
   logic [2:0]   r_size_q, r_size_d;
   logic [1:0]   r_burst_q, r_burst_d, r_resp_q, r_resp_d;
   logic [511:0] r_data_q, r_data_d;
   logic         r_err;

   w_state_e     w_state_q, w_state_d;
   logic [7:0]   w_id_q, w_id_d, w_len_q, w_len_d, w_beat_q, w_beat_d;
   logic [31:0]  w_addr_q, w_addr_d;
   logic [2:0]   w_size_q, w_size_d;
   logic [1:0]   w_burst_q, w_burst_d;
   logic         w_atop_q, w_atop_d, w_err_q, w_err_d;
   logic         w_err_beat, w_is_last;

   logic            mem_we;
   logic [IDXW-1:0] mem_widx;

   // Read channel: latch AR, fetch one word per beat, then present it until R handshake.
   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_addr_d  = r_addr_q;
      r_len_d   = r_len_q;
      r_size_d  = r_size_q;
      r_burst_d = r_burst_q;
      r_beat_d  = r_beat_q;
      r_data_d  = r_data_q;
      r_resp_d  = r_resp_q;
      r_err     = out_of_range(r_addr_q) || r_burst_q[1];
      case (r_state_q)
         R_IDLE: begin
            if (axi_req_i.ar_valid) begin
               r_id_d    = axi_req_i.ar_id;
               r_addr_d  = axi_req_i.ar_addr;
               r_len_d   = axi_req_i.ar_len;
               r_size_d  = axi_req_i.ar_size;
               r_burst_d = axi_req_i.ar_burst;
               r_beat_d  = 8'd0;
               r_state_d = R_FETCH;
            end
         end
         R_FETCH: begin
            r_data_d  = r_err ? '0 : mem_q[word_idx(r_addr_q)];
            r_resp_d  = r_err ? 2'b10 : 2'b00;
            r_state_d = R_DATA;
         end
         R_DATA: begin
            if (axi_req_i.r_ready) begin
               if (r_beat_q == r_len_q) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_addr_d  = next_addr(r_addr_q, r_size_q, r_burst_q);
                  r_beat_d  = r_beat_q + 8'd1;
                  r_state_d = R_FETCH;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Write channel: latch AW, accept one W beat per cycle, the beat counter ends the burst.
   always_comb begin
      w_state_d  = w_state_q;
      w_id_d     = w_id_q;
      w_addr_d   = w_addr_q;
      w_len_d    = w_len_q;
      w_size_d   = w_size_q;
      w_burst_d  = w_burst_q;
      w_atop_d   = w_atop_q;
      w_beat_d   = w_beat_q;
      w_err_d    = w_err_q;
      mem_we     = 1'b0;
      mem_widx   = word_idx(w_addr_q);
      w_err_beat = out_of_range(w_addr_q) || w_burst_q[1] || w_atop_q;
      w_is_last  = (w_beat_q == w_len_q);
      case (w_state_q)
         W_IDLE: begin
            if (axi_req_i.aw_valid) begin
               w_id_d    = axi_req_i.aw_id;
               w_addr_d  = axi_req_i.aw_addr;
               w_len_d   = axi_req_i.aw_len;
               w_size_d  = axi_req_i.aw_size;
               w_burst_d = axi_req_i.aw_burst;
               w_atop_d  = (axi_req_i.aw_atop != 6'd0);
               w_beat_d  = 8'd0;
               w_err_d   = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (axi_req_i.w_valid) begin
               mem_we = !w_err_beat;
               if (w_err_beat || (axi_req_i.w_last != w_is_last)) begin
                  w_err_d = 1'b1;
               end
               if (w_is_last) begin
                  w_state_d = W_RESP;
               end else begin
                  w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                  w_beat_d = w_beat_q + 8'd1;
               end
            end
         end
         W_RESP: begin
            if (axi_req_i.b_ready) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Channel state registers; reset parks both FSMs in IDLE with cleared payloads.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_size_q  <= '0;
         r_burst_q <= '0;
         r_beat_q  <= '0;
         r_data_q  <= '0;
         r_resp_q  <= '0;
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_size_q  <= '0;
         w_burst_q <= '0;
         w_atop_q  <= 1'b0;
         w_beat_q  <= '0;
         w_err_q   <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_addr_q  <= r_addr_d;
         r_len_q   <= r_len_d;
         r_size_q  <= r_size_d;
         r_burst_q <= r_burst_d;
         r_beat_q  <= r_beat_d;
         r_data_q  <= r_data_d;
         r_resp_q  <= r_resp_d;
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_addr_q  <= w_addr_d;
         w_len_q   <= w_len_d;
         w_size_q  <= w_size_d;
         w_burst_q <= w_burst_d;
         w_atop_q  <= w_atop_d;
         w_beat_q  <= w_beat_d;
         w_err_q   <= w_err_d;
      end
   end

   // Byte-enabled array write; contents survive reset, a same-cycle read sees the old word.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < 64; b++) begin
            if (axi_req_i.w_strb[b]) begin
               mem_q[mem_widx][b*8 +: 8] <= axi_req_i.w_data[b*8 +: 8];
            end
         end
      end
   end

   // Response channel outputs; rlast is qualified so it reads 0 whenever rvalid is low.
   always_comb begin
      axi_resp_o          = '0;
      axi_resp_o.ar_ready = (r_state_q == R_IDLE);
      axi_resp_o.r_valid  = (r_state_q == R_DATA);
      axi_resp_o.r_last   = (r_state_q == R_DATA) && (r_beat_q == r_len_q);
      axi_resp_o.r_id     = r_id_q;
      axi_resp_o.r_data   = r_data_q;
      axi_resp_o.r_resp   = r_resp_q;
      axi_resp_o.aw_ready = (w_state_q == W_IDLE);
      axi_resp_o.w_ready  = (w_state_q == W_DATA);
      axi_resp_o.b_valid  = (w_state_q == W_RESP);
      axi_resp_o.b_id     = w_id_q;
      axi_resp_o.b_resp   = {w_err_q, 1'b0};
   end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed scenarios plus random bursts against a word-map model.
// Latency: checks exact R/W/B cycle offsets relative to each handshake.
// Backpressure: stalls rready/bready/wvalid and expects stable payloads meanwhile.
module tb_axi_mem_responder;
   import fpga_pkg::*;

   localparam int unsigned MEM_BYTES = 65536;
   localparam logic [31:0] BASE      = 32'h8000_0000;
   localparam logic [1:0]  FIXED     = 2'b00;
   localparam logic [1:0]  INCR      = 2'b01;
   localparam logic [1:0]  WRAP      = 2'b10;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   mst_req_t  req;
   mst_resp_t resp;

   logic [7:0]   aw_id, ar_id, aw_len, ar_len;
   logic [31:0]  aw_addr, ar_addr;
   logic [2:0]   aw_size, ar_size;
   logic [1:0]   aw_burst, ar_burst;
   logic [5:0]   aw_atop;
   logic [511:0] w_data;
   logic [63:0]  w_strb;
   logic         aw_valid, w_valid, w_last, b_ready, ar_valid, r_ready;

   always_comb begin
      req          = '0;
      req.aw_id    = aw_id;
      req.aw_addr  = aw_addr;
      req.aw_len   = aw_len;
      req.aw_size  = aw_size;
      req.aw_burst = aw_burst;
      req.aw_atop  = aw_atop;
      req.aw_valid = aw_valid;
      req.w_data   = w_data;
      req.w_strb   = w_strb;
      req.w_last   = w_last;
      req.w_valid  = w_valid;
      req.b_ready  = b_ready;
      req.ar_id    = ar_id;
      req.ar_addr  = ar_addr;
      req.ar_len   = ar_len;
      req.ar_size  = ar_size;
      req.ar_burst = ar_burst;
      req.ar_valid = ar_valid;
      req.r_ready  = r_ready;
   end

   axi_mem_responder #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE)) dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .axi_req_i  (req),
      .axi_resp_o (resp)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
   endtask

   // Reference memory: word index -> 512-bit contents, updated as W beats are accepted.
   logic [511:0] mdl [int];
   logic [511:0] wbuf_dat [256];
   logic [63:0]  wbuf_stb [256];

   function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                             input logic [2:0] sz, input logic [1:0] bu);
      if (bu == FIXED) return a;
      return a + (32'(i) << sz);
   endfunction

   function automatic bit beat_bad(input logic [31:0] a, input logic [1:0] bu, input logic [5:0] atop);
      longint unsigned la;
      la = 64'(a);
      return (la < 64'(BASE)) || (la >= 64'(BASE) + 64'(MEM_BYTES)) || (bu >= 2'b10) || (atop != 6'd0);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 6);
   endfunction

   task automatic fill_rand(input int n, input bit full);
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < 16; c++) wbuf_dat[i][c*32 +: 32] = $urandom;
         wbuf_stb[i] = full ? '1 : {$urandom, $urandom};
      end
   endtask

   task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu, input logic [5:0] atop,
                           input bit bad_last, input int abort_at, input bit stall);
      bit          exp_err;
      int          n;
      int          w;
      logic [31:0] a;
      exp_err = bad_last;
      @(negedge clk);
      aw_id = id; aw_addr = addr; aw_len = len; aw_size = sz; aw_burst = bu; aw_atop = atop;
      aw_valid = 1'b1;
      n = 0;
      while (!resp.aw_ready && n < 100) begin @(negedge clk); n++; end
      check("aw_ready", 512'(resp.aw_ready), 512'(1));
      @(negedge clk);
      aw_valid = 1'b0;
      check("aw_ready_busy", 512'(resp.aw_ready), 512'(0));
      check("w_ready_lat", 512'(resp.w_ready), 512'(1));
      for (int i = 0; i <= int'(len); i++) begin
         if (i == abort_at) begin
            w_valid = 1'b0;
            rstn    = 1'b0;
            @(negedge clk);
            check("rst_r_valid", 512'(resp.r_valid), 512'(0));
            check("rst_b_valid", 512'(resp.b_valid), 512'(0));
            check("rst_w_ready", 512'(resp.w_ready), 512'(0));
            check("rst_ar_ready", 512'(resp.ar_ready), 512'(1));
            check("rst_aw_ready", 512'(resp.aw_ready), 512'(1));
            rstn = 1'b1;
            @(negedge clk);
            return;
         end
         if (stall && $urandom_range(0, 2) == 0) begin
            w_valid = 1'b0;
            @(negedge clk);
         end
         a       = beat_addr(addr, i, sz, bu);
         w_data  = wbuf_dat[i];
         w_strb  = wbuf_stb[i];
         w_last  = (i == int'(len)) ^ bad_last;
         w_valid = 1'b1;
         n = 0;
         while (!resp.w_ready && n < 100) begin @(negedge clk); n++; end
         check("w_ready", 512'(resp.w_ready), 512'(1));
         if (beat_bad(a, bu, atop)) begin
            exp_err = 1'b1;
         end else begin
            w = widx(a);
            for (int b = 0; b < 64; b++)
               if (w_strb[b]) mdl[w][b*8 +: 8] = w_data[b*8 +: 8];
         end
         @(negedge clk);
      end
      w_valid = 1'b0;
      w_last  = 1'b0;
      n = $urandom_range(0, 2);
      for (int s = 0; s <= n; s++) begin
         if (s > 0) @(negedge clk);
         check("b_valid", 512'(resp.b_valid), 512'(1));
         check("b_id", 512'(resp.b_id), 512'(id));
         check("b_resp", 512'(resp.b_resp), exp_err ? 512'(2) : 512'(0));
      end
      b_ready = 1'b1;
      @(negedge clk);
      b_ready = 1'b0;
      check("b_valid_drop", 512'(resp.b_valid), 512'(0));
      check("aw_ready_idle", 512'(resp.aw_ready), 512'(1));
   endtask

   task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu, input bit toggle);
      int           n;
      int           gap;
      bit           tgl;
      bit           bad;
      logic [31:0]  a;
      logic [511:0] exp_dat;
      tgl = 1'b0;
      @(negedge clk);
      ar_id = id; ar_addr = addr; ar_len = len; ar_size = sz; ar_burst = bu;
      ar_valid = 1'b1;
      n = 0;
      while (!resp.ar_ready && n < 100) begin @(negedge clk); n++; end
      check("ar_ready", 512'(resp.ar_ready), 512'(1));
      @(negedge clk);
      ar_valid = 1'b0;
      check("ar_ready_busy", 512'(resp.ar_ready), 512'(0));
      for (int i = 0; i <= int'(len); i++) begin
         a       = beat_addr(addr, i, sz, bu);
         bad     = beat_bad(a, bu, 6'd0);
         exp_dat = bad ? '0 : mdl[widx(a)];
         gap = 1;
         while (!resp.r_valid && gap < 100) begin @(negedge clk); gap++; end
         check("r_gap", 512'(gap), 512'(2));
         do begin
            check("r_valid", 512'(resp.r_valid), 512'(1));
            check("r_data", resp.r_data, exp_dat);
            check("r_id", 512'(resp.r_id), 512'(id));
            check("r_resp", 512'(resp.r_resp), bad ? 512'(2) : 512'(0));
            check("r_last", 512'(resp.r_last), 512'(i == int'(len)));
            if (toggle) begin
               tgl     = ~tgl;
               r_ready = tgl;
            end else begin
               r_ready = 1'b1;
            end
            if (!r_ready) @(negedge clk);
         end while (!r_ready);
         @(negedge clk);
         r_ready = 1'b0;
      end
      check("ar_ready_idle", 512'(resp.ar_ready), 512'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  rid, rlen;
      logic [2:0]  rsz;
      logic [1:0]  rbu;
      logic [31:0] raddr;
      rstn = 1'b0;
      aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_atop = '0;
      aw_valid = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
      ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_valid = 1'b0;
      r_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_r_valid", 512'(resp.r_valid), 512'(0));
      check("reset_b_valid", 512'(resp.b_valid), 512'(0));
      check("reset_w_ready", 512'(resp.w_ready), 512'(0));
      check("reset_ar_ready", 512'(resp.ar_ready), 512'(1));
      check("reset_aw_ready", 512'(resp.aw_ready), 512'(1));
      check("reset_r_data", resp.r_data, 512'(0));
      check("reset_r_id", 512'(resp.r_id), 512'(0));
      check("reset_r_resp", 512'(resp.r_resp), 512'(0));
      check("reset_r_last", 512'(resp.r_last), 512'(0));
      check("reset_b_id", 512'(resp.b_id), 512'(0));
      check("reset_b_resp", 512'(resp.b_resp), 512'(0));
      rstn = 1'b1;

      // Known contents for words 0..127 and the top two words of the array.
      for (int k = 0; k < 8; k++) begin
         fill_rand(16, 1'b1);
         do_write(8'(k), BASE + 32'(k * 1024), 8'd15, 3'd6, INCR, 6'd0, 1'b0, -1, 1'b0);
      end
      fill_rand(2, 1'b1);
      do_write(8'h77, BASE + 32'(MEM_BYTES) - 32'd128, 8'd1, 3'd6, INCR, 6'd0, 1'b0, -1, 1'b0);

      // Single beat of 0xA5.
      wbuf_dat[0] = {64{8'hA5}};
      wbuf_stb[0] = '1;
      do_write(8'h12, 32'h8000_0040, 8'd0, 3'd6, INCR, 6'd0, 1'b0, -1, 1'b0);
      do_read(8'h12, 32'h8000_0040, 8'd0, 3'd6, INCR, 1'b0);

      // INCR burst carrying beat index, read back with rready toggling.
      for (int i = 0; i < 4; i++) begin
         wbuf_dat[i] = 512'(i);
         wbuf_stb[i] = '1;
      end
      do_write(8'h34, 32'h8000_1000, 8'd3, 3'd6, INCR, 6'd0, 1'b0, -1, 1'b0);
      do_read(8'h35, 32'h8000_1000, 8'd3, 3'd6, INCR, 1'b1);

      // Partial strobes over a preloaded word.
      wbuf_dat[0] = {64{8'h22}};
      wbuf_stb[0] = '1;
      do_write(8'h40, 32'h8000_0080, 8'd0, 3'd6, INCR, 6'd0, 1'b0, -1, 1'b0);
      wbuf_dat[0] = {64{8'h11}};
      wbuf_stb[0] = 64'h0000_0000_0000_00FF;
      do_write(8'h41, 32'h8000_0080, 8'd0, 3'd6, INCR, 6'd0, 1'b0, -1, 1'b0);
      do_read(8'h42, 32'h8000_0080, 8'd0, 3'd6, INCR, 1'b0);

      // Error cases: below base, WRAP write, atomic write, burst crossing the top of the array.
      do_read(8'h50, 32'h7FFF_FFC0, 8'd0, 3'd6, INCR, 1'b0);
      fill_rand(4, 1'b1);
      do_write(8'h51, 32'h8000_0000, 8'd3, 3'd6, WRAP, 6'd0, 1'b0, -1, 1'b0);
      do_read(8'h52, 32'h8000_0000, 8'd0, 3'd6, INCR, 1'b0);
      fill_rand(1, 1'b1);
      do_write(8'h53, 32'h8000_0100, 8'd0, 3'd6, INCR, 6'h20, 1'b0, -1, 1'b0);
      do_read(8'h54, 32'h8000_0100, 8'd0, 3'd6, INCR, 1'b0);
      do_read(8'h55, BASE + 32'(MEM_BYTES) - 32'd128, 8'd3, 3'd6, INCR, 1'b0);
      fill_rand(4, 1'b1);
      do_write(8'h56, BASE + 32'(MEM_BYTES) - 32'd128, 8'd3, 3'd6, INCR, 6'd0, 1'b0, -1, 1'b0);
      do_read(8'h57, BASE + 32'(MEM_BYTES) - 32'd128, 8'd3, 3'd6, FIXED, 1'b0);
      fill_rand(1, 1'b1);
      do_write(8'h58, BASE + 32'd200 * 32'd64, 8'd0, 3'd6, INCR, 6'd0, 1'b1, -1, 1'b0);

      // Concurrent read and write bursts to disjoint words.
      fill_rand(8, 1'b1);
      fork
         do_read(8'hA1, BASE + 32'd16 * 32'd64, 8'd7, 3'd6, INCR, 1'b0);
         do_write(8'hB2, BASE + 32'd40 * 32'd64, 8'd7, 3'd6, INCR, 6'd0, 1'b0, -1, 1'b1);
      join
      do_read(8'hB3, BASE + 32'd40 * 32'd64, 8'd7, 3'd6, INCR, 1'b0);

      // Reset in the middle of a write burst, then normal traffic.
      fill_rand(8, 1'b1);
      do_write(8'hC0, BASE + 32'd60 * 32'd64, 8'd7, 3'd6, INCR, 6'd0, 1'b0, 3, 1'b0);
      fill_rand(1, 1'b1);
      do_write(8'hC1, BASE + 32'd70 * 32'd64, 8'd0, 3'd6, INCR, 6'd0, 1'b0, -1, 1'b0);
      do_read(8'hC2, BASE + 32'd60 * 32'd64, 8'd3, 3'd6, INCR, 1'b0);
      do_read(8'hC3, BASE + 32'd70 * 32'd64, 8'd0, 3'd6, INCR, 1'b0);

      // Random mix of sizes, bursts and strobes within the preloaded region.
      for (int it = 0; it < 24; it++) begin
         rid  = 8'($urandom);
         rlen = 8'($urandom_range(0, 7));
         rsz  = 3'($urandom_range(0, 6));
         rbu  = ($urandom_range(0, 7) == 0) ? WRAP : 2'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0)
            raddr = BASE - 32'($urandom_range(1, 4)) * 32'd64;
         else
            raddr = BASE + 32'($urandom_range(0, 119)) * 32'd64 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 0) begin
            fill_rand(int'(rlen) + 1, 1'b0);
            do_write(rid, raddr, rlen, rsz, rbu, 6'd0, 1'b0, -1, 1'($urandom_range(0, 1)));
         end else begin
            do_read(rid, raddr, rlen, rsz, rbu, 1'($urandom_range(0, 1)));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
